// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: per-stage destination tag and the hard-wired zero register.
package hazard_ctrl_pkg;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } stage_tag_t;

endpackage

// File: rtl/hazard_match.sv
// Purpose: compare one decode source index against one in-flight tag. Latency: combinational.
// Backpressure: none; load_only restricts the match to load producers (load-use detection).
module hazard_match
    import hazard_ctrl_pkg::*;
(
    input  logic       src_used,
    input  logic [4:0] src_idx,
    input  stage_tag_t tag,
    input  logic       load_only,
    output logic       match
);

    assign match = src_used && tag.valid && (src_idx != ZERO_REG) && (src_idx == tag.rd)
                   && (!load_only || tag.is_load);

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: RAW hazard detection over EX/MEM/WB destination tags, with stall statistics.
// Latency: stall is combinational, tags advance every cycle; stall holds IF/ID and bubbles EX.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             flush,
    output logic             stall,
    output logic             forward,
    output logic [4:0]       ex_stage_rd,
    output logic [4:0]       mem_stage_rd,
    output logic [4:0]       wb_stage_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic FWD = (FWD_EN != 0);

    stage_tag_t       ex_q, ex_d, mem_q, wb_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    stage_tag_t [2:0] stage_tags;
    logic       [2:0] m_rs1, m_rs2;
    logic             hazard;

    assign stage_tags = {wb_q, mem_q, ex_q};

    // With forwarding only a load still in EX is unreachable; every other producer is bypassed.
    for (genvar s = 0; s < 3; s++) begin : g_stage
        hazard_match u_m_rs1 (
            .src_used  (id_uses_rs1),
            .src_idx   (id_rs1),
            .tag       (stage_tags[s]),
            .load_only ((s == 0) ? FWD : 1'b0),
            .match     (m_rs1[s])
        );
        hazard_match u_m_rs2 (
            .src_used  (id_uses_rs2),
            .src_idx   (id_rs2),
            .tag       (stage_tags[s]),
            .load_only ((s == 0) ? FWD : 1'b0),
            .match     (m_rs2[s])
        );
    end

    always_comb begin
        hazard = 1'b0;
        if (FWD) begin
            hazard = m_rs1[0] | m_rs2[0];
        end else begin
            hazard = |{m_rs1, m_rs2};
        end
        stall = id_valid && hazard && !flush;

        ex_d = '0;
        if (!stall && !flush) begin
            ex_d.valid   = id_valid && id_wr_en && (id_rd != ZERO_REG);
            ex_d.rd      = id_rd;
            ex_d.is_load = id_is_load;
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            cnt_q <= cnt_d;
        end
    end

    assign forward      = FWD;
    assign ex_stage_rd  = ex_q.valid  ? ex_q.rd  : ZERO_REG;
    assign mem_stage_rd = mem_q.valid ? mem_q.rd : ZERO_REG;
    assign wb_stage_rd  = wb_q.valid  ? wb_q.rd  : ZERO_REG;
    assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench: forwarding and non-forwarding instances share stimulus; a list-of-producers model predicts both.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0, id_wr_en = 1'b0, id_is_load = 1'b0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       flush = 1'b0;

    logic        stall_f, fwd_f, stall_n, fwd_n;
    logic [4:0]  ex_f, mem_f, wb_f, ex_n, mem_n, wb_n;
    logic [15:0] cnt_f;
    logic [2:0]  cnt_n;

    always #5 clk = ~clk;

    hazard_ctrl #(.FWD_EN(1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .flush(flush), .stall(stall_f), .forward(fwd_f), .ex_stage_rd(ex_f),
        .mem_stage_rd(mem_f), .wb_stage_rd(wb_f), .stall_cnt(cnt_f)
    );

    hazard_ctrl #(.FWD_EN(0), .CNT_W(3)) u_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .flush(flush), .stall(stall_n), .forward(fwd_n), .ex_stage_rd(ex_n),
        .mem_stage_rd(mem_n), .wb_stage_rd(wb_n), .stall_cnt(cnt_n)
    );

    // Model: per config, the producers still in flight (index 0 = youngest) and a stall tally.
    typedef struct { bit v; int rd; bit ld; } inst_t;
    inst_t pipe [2][3];
    int    cnt  [2];
    int    cnt_max [2] = '{65535, 7};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic bit src_hit(inst_t e, bit used, int idx);
        return used && e.v && idx != 0 && idx == e.rd;
    endfunction

    // Forwarding: only a load one instruction ahead is too late. No forwarding: any unretired writer blocks.
    function automatic bit exp_stall(int c);
        bit h = 0;
        if (!id_valid || flush) return 0;
        if (c == 0) begin
            h = pipe[0][0].ld && (src_hit(pipe[0][0], id_uses_rs1, id_rs1) ||
                                  src_hit(pipe[0][0], id_uses_rs2, id_rs2));
        end else begin
            foreach (pipe[1][s])
                h |= src_hit(pipe[1][s], id_uses_rs1, id_rs1) || src_hit(pipe[1][s], id_uses_rs2, id_rs2);
        end
        return h;
    endfunction

    function automatic int exp_rd(int c, int s);
        return pipe[c][s].v ? pipe[c][s].rd : 0;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < 2; c++) begin
            cnt[c] = 0;
            for (int s = 0; s < 3; s++) pipe[c][s] = '{0, 0, 0};
        end
    endfunction

    function automatic void model_advance(int c, bit s);
        pipe[c][2] = pipe[c][1];
        pipe[c][1] = pipe[c][0];
        if (s || flush) pipe[c][0] = '{0, 0, 0};
        else pipe[c][0] = '{id_valid && id_wr_en && id_rd != 0, int'(id_rd), id_is_load};
        if (s) cnt[c] = (cnt[c] < cnt_max[c]) ? cnt[c] + 1 : cnt_max[c];
    endfunction

    task automatic check_model();
        chk("stall_f", stall_f, exp_stall(0));
        chk("stall_n", stall_n, exp_stall(1));
        chk("fwd_f", fwd_f, 1);
        chk("fwd_n", fwd_n, 0);
        chk("ex_f",  ex_f,  exp_rd(0, 0));
        chk("mem_f", mem_f, exp_rd(0, 1));
        chk("wb_f",  wb_f,  exp_rd(0, 2));
        chk("ex_n",  ex_n,  exp_rd(1, 0));
        chk("mem_n", mem_n, exp_rd(1, 1));
        chk("wb_n",  wb_n,  exp_rd(1, 2));
        chk("cnt_f", cnt_f, cnt[0]);
        chk("cnt_n", cnt_n, cnt[1]);
    endtask

    // Called #1 after a rising edge with inputs already applied.
    task automatic step();
        bit s0, s1;
        #2;
        s0 = exp_stall(0);
        s1 = exp_stall(1);
        check_model();
        @(posedge clk);
        model_advance(0, s0);
        model_advance(1, s1);
        #1;
    endtask

    task automatic set_id(input bit v, input bit wr, input bit ld, input bit u1, input logic [4:0] r1,
                          input bit u2, input logic [4:0] r2, input logic [4:0] rd);
        id_valid = v; id_wr_en = wr; id_is_load = ld;
        id_uses_rs1 = u1; id_rs1 = r1; id_uses_rs2 = u2; id_rs2 = r2; id_rd = rd;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_clear();
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b0;
    endtask

    initial begin
        model_clear();
        #2;
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Load followed by dependent add: one bubble, then the load sits in MEM.
        do_reset();
        set_id(1, 1, 1, 0, 0, 0, 0, 5); step();
        set_id(1, 1, 0, 1, 5, 1, 1, 6);
        #2; chk("lu_stall", stall_f, 1);
        step();
        chk("lu_ex_bubble", ex_f, 0);
        chk("lu_mem_rd", mem_f, 5);
        chk("lu_cnt", cnt_f, 1);
        #2; chk("lu_release", stall_f, 0);
        step();

        // ALU producer is forwarded, no stall.
        do_reset();
        set_id(1, 1, 0, 0, 0, 0, 0, 5); step();
        set_id(1, 1, 0, 1, 5, 1, 5, 7);
        #2;
        chk("alu_stall", stall_f, 0);
        chk("alu_ex_rd", ex_f, 5);
        chk("alu_fwd", fwd_f, 1);
        step();

        // x0 never creates a hazard or a valid tag.
        do_reset();
        set_id(1, 1, 1, 0, 0, 0, 0, 0); step();
        set_id(1, 1, 0, 1, 0, 1, 0, 1);
        #2;
        chk("x0_stall", stall_f, 0);
        chk("x0_ex_rd", ex_f, 0);
        step();

        // Flush beats a load-use stall.
        do_reset();
        set_id(1, 1, 1, 0, 0, 0, 0, 5); step();
        set_id(1, 1, 0, 1, 5, 0, 0, 6);
        flush = 1'b1;
        #2; chk("fl_stall", stall_f, 0);
        step();
        flush = 1'b0;
        chk("fl_ex_bubble", ex_f, 0);
        chk("fl_mem_rd", mem_f, 5);
        chk("fl_cnt", cnt_f, 0);

        // No forwarding: consumer waits until the producer retires, then saturation.
        do_reset();
        set_id(1, 1, 0, 0, 0, 0, 0, 3); step();
        set_id(1, 1, 0, 1, 3, 0, 0, 8);
        for (int i = 0; i < 4; i++) step();
        chk("nf_cnt3", cnt_n, 3);
        chk("nf_fwd", fwd_n, 0);
        for (int k = 0; k < 2; k++) begin
            set_id(1, 1, 0, 0, 0, 0, 0, 3); step();
            set_id(1, 1, 0, 1, 3, 0, 0, 8);
            for (int i = 0; i < 4; i++) step();
        end
        chk("nf_sat", cnt_n, 7);

        // Asynchronous reset in the middle of a stall.
        set_id(1, 1, 0, 0, 0, 0, 0, 3); step();
        set_id(1, 1, 0, 1, 3, 0, 0, 8);
        #2; chk("mr_stall_pre", stall_n, 1);
        rst = 1'b0;
        #1;
        model_clear();
        chk("mr_stall", stall_n, 0);
        chk("mr_cnt", cnt_n, 0);
        chk("mr_ex", ex_n, 0);
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        // Random traffic on a small register window to force frequent collisions.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                   $urandom_range(0, 1), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            flush = ($urandom_range(0, 7) == 0);
            step();
        end
        flush = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter FWD_EN, default 1, meaning 1 drives the forwarding path and 0 holds forward low and resolves every RAW hazard by stalling.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the stall statistics counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have ports id_valid, id_wr_en, id_is_load, id_uses_rs1, id_uses_rs2, each input, 1 bit: qualifiers for the decode-stage instruction.
REQ-006 The block SHALL have ports id_rs1, id_rs2, id_rd, each input, 5 bits: decode-stage source and destination register indices.
REQ-007 The block SHALL have port flush, input, 1 bit: squash the decode and EX entries (branch redirect).
REQ-008 The block SHALL have port stall, output, 1 bit: hold PC and IF/ID, and insert a bubble into EX.
REQ-009 The block SHALL have port forward, output, 1 bit: forwarding enable to the register file.
REQ-010 The block SHALL have ports ex_stage_rd, mem_stage_rd, wb_stage_rd, each output, 5 bits: in-flight destination tags, 0 when the stage is empty or does not write.
REQ-011 The block SHALL have port stall_cnt, output, CNT_W bits: count of stall cycles.

Function
REQ-012 Three tag registers (EX, MEM, WB) SHALL each hold {valid, rd, is_load}; each cycle EX→MEM→WB shifts, and WB retires.
REQ-013 When stall=0, the EX entry SHALL load {id_valid & id_wr_en & (id_rd≠0), id_rd, id_is_load}; when stall=1 or flush=1, the EX entry SHALL load an invalid bubble.
REQ-014 Stage tag outputs SHALL be registered, and each SHALL equal rd when its entry is valid, else 0.
REQ-015 forward SHALL equal FWD_EN combinationally.
REQ-016 Load-use hazard (FWD_EN=1): stall SHALL be 1 when id_valid and the EX entry is a valid load and (id_uses_rs1 & id_rs1==EX.rd, or id_uses_rs2 & id_rs2==EX.rd), with EX.rd≠0.
REQ-017 With FWD_EN=0, stall SHALL be 1 when any valid EX, MEM or WB entry matches a used source index other than 0.
REQ-018 stall SHALL be combinational from current tags and ID inputs; a load-use stall SHALL last exactly 1 cycle, after which the load sits in MEM and is forwardable.
REQ-019 flush SHALL have priority over stall: when flush=1, stall SHALL be forced to 0 that cycle, and MEM/WB SHALL still advance normally.
REQ-020 Register x0 SHALL never create a hazard or a valid tag.
REQ-021 stall_cnt SHALL increment on every cycle with stall=1 and saturate at all-ones (no wrap).
REQ-022 With simultaneous matches, the hazard condition SHALL be the OR of all per-source matches; no priority between stages is needed because stall is a single bit.

Reset
REQ-023 On rst low, all tag entries SHALL be invalid and stall_cnt SHALL be 0, asynchronously.
REQ-024 During reset, the stage tag outputs SHALL be 0 and stall SHALL be 0.
REQ-025 Deassertion mid-program SHALL leave no stale hazard; the first decode after release SHALL see empty stages.

Structure
REQ-026 The stage-tag struct {valid, rd[4:0], is_load} and the ZERO_REG constant SHALL be placed in the shared package / sys_defs.
REQ-027 The block SHALL have one natural sub-module, hazard_match: a combinational comparator of one source index against one tag, instantiated per source and stage.
REQ-028 The block SHALL contain no datapath; result values remain in the pipeline stages.

Verification
REQ-029 lw x5 then add x6,x5,x1 (FWD_EN=1) → stall=1 for 1 cycle, EX bubble, then ex_stage_rd=0 and mem_stage_rd=5, stall_cnt=1.
REQ-030 add x5 then sub x7,x5,x5 (FWD_EN=1) → no stall, ex_stage_rd=5 when the sub is in decode, forward=1.
REQ-031 lw x0 then add x1,x0,x0 → no stall, ex_stage_rd=0.
REQ-032 lw x5, consumer of x5 in decode, and flush=1 in the same cycle → stall=0, EX bubble, stall_cnt unchanged.
REQ-033 FWD_EN=0, add x3 then an x3 consumer → stall=1 for 3 cycles until WB retires, stall_cnt=3, forward=0.
REQ-034 Preset stall_cnt to all-ones−1, then 3 stall cycles → saturates at all-ones; assert rst mid-stall → all outputs 0 immediately.
